// File: rtl/wb_write_queue_pkg.sv
// Shared widths, constants and the queue entry record for the writeback queue.
package wb_write_queue_pkg;

  localparam int unsigned N_BITS     = 32;
  localparam int unsigned DEPTH      = 4;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  // Data field width follows N_BITS; instances must keep N_bits equal to it.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] regnum;
    logic [N_BITS-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/wb_match_unit.sv
// Youngest-match search of one query register over the queue and the output stage.
module wb_match_unit
  import wb_write_queue_pkg::*;
#(
  parameter int unsigned N_bits    = N_BITS,
  parameter int unsigned N_ENTRIES = DEPTH
) (
  input  logic [REG_ADDR_W-1:0] query_i,
  input  wb_entry_t             entries_i [N_ENTRIES],
  input  logic [N_ENTRIES-1:0]  valid_i,
  input  logic                  out_valid_i,
  input  logic [REG_ADDR_W-1:0] out_reg_i,
  input  logic [N_bits-1:0]     out_data_i,
  output logic                  pending_o,
  output logic [N_bits-1:0]     fwd_data_o
);

  // entries_i is oldest-first, so a later match overrides an earlier one.
  always_comb begin
    pending_o  = 1'b0;
    fwd_data_o = '0;
    if (query_i != REG_ZERO) begin
      if (out_valid_i && (out_reg_i == query_i)) begin
        pending_o  = 1'b1;
        fwd_data_o = out_data_i;
      end
      for (int unsigned i = 0; i < N_ENTRIES; i++) begin
        if (valid_i[i] && (entries_i[i].regnum == query_i)) begin
          pending_o  = 1'b1;
          fwd_data_o = N_bits'(entries_i[i].data);
        end
      end
    end
  end

endmodule

// File: rtl/wb_write_queue.sv
// Writeback queue: buffers register writes until the register-file port is free,
// and exposes pending/forwarding lookups for two read ports.
module wb_write_queue
  import wb_write_queue_pkg::*;
#(
  parameter int unsigned N_bits = wb_write_queue_pkg::N_BITS,
  parameter int unsigned DEPTH  = wb_write_queue_pkg::DEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wb_valid_i,
  output logic                      wb_ready_o,
  input  logic [REG_ADDR_W-1:0]     wb_reg_i,
  input  logic [N_bits-1:0]         wb_data_i,
  input  logic                      drain_en_i,
  output logic                      Reg_Write_o,
  output logic [REG_ADDR_W-1:0]     Write_Register_o,
  output logic [N_bits-1:0]         Write_Data_o,
  input  logic [REG_ADDR_W-1:0]     Query_Register_1_i,
  input  logic [REG_ADDR_W-1:0]     Query_Register_2_i,
  output logic                      Pending_1_o,
  output logic                      Pending_2_o,
  output logic [N_bits-1:0]         Fwd_Data_1_o,
  output logic [N_bits-1:0]         Fwd_Data_2_o,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  wb_entry_t             mem_q [DEPTH];
  wb_entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  reg_write_q, reg_write_d;
  logic [REG_ADDR_W-1:0] wr_reg_q, wr_reg_d;
  logic [N_bits-1:0]     wr_data_q, wr_data_d;
  logic                  accept, store, pop;
  wb_entry_t             aged [DEPTH];
  logic [DEPTH-1:0]      aged_valid;

  assign wb_ready_o = (count_q < CNT_W'(DEPTH));

  // Register-0 writes are handshaken but dropped, since r0 is never written.
  always_comb begin
    accept      = wb_valid_i && wb_ready_o;
    store       = accept && (wb_reg_i != REG_ZERO);
    pop         = (count_q != '0) && drain_en_i;
    mem_d       = mem_q;
    head_d      = head_q;
    tail_d      = tail_q;
    reg_write_d = pop;
    wr_reg_d    = wr_reg_q;
    wr_data_d   = wr_data_q;
    if (store) begin
      mem_d[tail_q] = '{regnum: wb_reg_i, data: N_BITS'(wb_data_i)};
      tail_d        = tail_q + PTR_W'(1);
    end
    if (pop) begin
      wr_reg_d  = mem_q[head_q].regnum;
      wr_data_d = N_bits'(mem_q[head_q].data);
      head_d    = head_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(store) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      reg_write_q <= 1'b0;
      wr_reg_q    <= '0;
      wr_data_q   <= '0;
    end else begin
      mem_q       <= mem_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      reg_write_q <= reg_write_d;
      wr_reg_q    <= wr_reg_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Rotate storage into age order (index 0 = head) for the match units.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      aged[i]       = mem_q[head_q + PTR_W'(i)];
      aged_valid[i] = (CNT_W'(i) < count_q);
    end
  end

  wb_match_unit #(.N_bits(N_bits), .N_ENTRIES(DEPTH)) u_match_1 (
    .query_i     (Query_Register_1_i),
    .entries_i   (aged),
    .valid_i     (aged_valid),
    .out_valid_i (reg_write_q),
    .out_reg_i   (wr_reg_q),
    .out_data_i  (wr_data_q),
    .pending_o   (Pending_1_o),
    .fwd_data_o  (Fwd_Data_1_o)
  );

  wb_match_unit #(.N_bits(N_bits), .N_ENTRIES(DEPTH)) u_match_2 (
    .query_i     (Query_Register_2_i),
    .entries_i   (aged),
    .valid_i     (aged_valid),
    .out_valid_i (reg_write_q),
    .out_reg_i   (wr_reg_q),
    .out_data_i  (wr_data_q),
    .pending_o   (Pending_2_o),
    .fwd_data_o  (Fwd_Data_2_o)
  );

  assign Reg_Write_o      = reg_write_q;
  assign Write_Register_o = wr_reg_q;
  assign Write_Data_o     = wr_data_q;
  assign count_o          = count_q;

endmodule

// File: tb/tb_wb_write_queue.sv
// Scoreboard bench for wb_write_queue: accepted writes are queued and matched
// against every register-file write, plus directed occupancy/forwarding checks.
module tb_wb_write_queue;

  localparam int unsigned NB = 32;
  localparam int unsigned D  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          wb_valid_i;
  logic          wb_ready_o;
  logic [4:0]    wb_reg_i;
  logic [NB-1:0] wb_data_i;
  logic          drain_en_i;
  logic          Reg_Write_o;
  logic [4:0]    Write_Register_o;
  logic [NB-1:0] Write_Data_o;
  logic [4:0]    Query_Register_1_i, Query_Register_2_i;
  logic          Pending_1_o, Pending_2_o;
  logic [NB-1:0] Fwd_Data_1_o, Fwd_Data_2_o;
  logic [2:0]    count_o;

  wb_write_queue #(.N_bits(NB), .DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .wb_valid_i(wb_valid_i), .wb_ready_o(wb_ready_o),
    .wb_reg_i(wb_reg_i), .wb_data_i(wb_data_i),
    .drain_en_i(drain_en_i),
    .Reg_Write_o(Reg_Write_o), .Write_Register_o(Write_Register_o),
    .Write_Data_o(Write_Data_o),
    .Query_Register_1_i(Query_Register_1_i), .Query_Register_2_i(Query_Register_2_i),
    .Pending_1_o(Pending_1_o), .Pending_2_o(Pending_2_o),
    .Fwd_Data_1_o(Fwd_Data_1_o), .Fwd_Data_2_o(Fwd_Data_2_o),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]    r;
    logic [NB-1:0] d;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  bit          last_acc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic drive(input bit v, input logic [4:0] r, input logic [NB-1:0] d, input bit dr);
    wb_valid_i = v;
    wb_reg_i   = r;
    wb_data_i  = d;
    drain_en_i = dr;
  endtask

  // One clock: record the expected write if the handshake will complete, then
  // advance to the following falling edge where outputs are stable.
  task automatic step();
    last_acc = wb_valid_i && wb_ready_o && !reset;
    if (last_acc && wb_reg_i != 5'd0) sb.push_back('{r: wb_reg_i, d: wb_data_i});
    @(posedge clk);
    @(negedge clk);
    if (reset) sb.delete();
  endtask

  task automatic drain_all();
    drive(1'b0, 5'd0, '0, 1'b1);
    for (int i = 0; i < 2 * D + 2 && count_o != 3'd0; i++) step();
    step();
    check("drained_count", count_o, 0);
    check("drained_sb_empty", sb.size(), 0);
  endtask

  // Every register-file write must be the oldest outstanding accepted entry.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (Reg_Write_o === 1'b1) begin
      if (sb.size() == 0) check("spurious_write", Reg_Write_o, 0);
      else begin
        e = sb.pop_front();
        check("wr_reg", Write_Register_o, e.r);
        check("wr_data", Write_Data_o, e.d);
      end
    end
  end

  initial begin
    reset = 1'b1;
    Query_Register_1_i = 5'd8;
    Query_Register_2_i = 5'd9;
    drive(1'b0, 5'd0, '0, 1'b0);
    @(negedge clk);
    step();
    step();
    check("rst_ready", wb_ready_o, 1);
    check("rst_count", count_o, 0);
    check("rst_regwrite", Reg_Write_o, 0);
    check("rst_wreg", Write_Register_o, 0);
    check("rst_wdata", Write_Data_o, 0);
    check("rst_pend1", Pending_1_o, 0);
    check("rst_pend2", Pending_2_o, 0);
    reset = 1'b0;

    // Single write: accept at edge 0, write visible only after edge 1.
    drive(1'b1, 5'd8, 32'h0000_00AA, 1'b1);
    step();
    drive(1'b0, 5'd0, '0, 1'b1);
    check("single_rw_edge0", Reg_Write_o, 0);
    check("single_count", count_o, 1);
    step();
    check("single_rw_edge1", Reg_Write_o, 1);
    check("single_wreg", Write_Register_o, 8);
    check("single_wdata", Write_Data_o, 32'hAA);
    step();
    check("single_rw_edge2", Reg_Write_o, 0);
    check("single_wreg_hold", Write_Register_o, 8);

    // Fill and stall, then drain with reg 5 still offered.
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 5'(i), 32'h100 + 32'(i), 1'b0);
      step();
    end
    check("full_count", count_o, 4);
    check("full_ready", wb_ready_o, 0);
    check("full_reg5_rejected", last_acc, 0);
    drive(1'b1, 5'd5, 32'h105, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step();
      if (last_acc) break;
    end
    check("reg5_accepted", last_acc, 1);
    drain_all();

    // Register 0 is handshaken but never stored or written.
    drive(1'b1, 5'd0, 32'hDEAD, 1'b1);
    Query_Register_1_i = 5'd0;
    step();
    check("zero_accepted", last_acc, 1);
    check("zero_count", count_o, 0);
    drive(1'b0, 5'd0, '0, 1'b1);
    step();
    check("zero_rw", Reg_Write_o, 0);
    step();
    check("zero_rw_late", Reg_Write_o, 0);
    check("zero_pend", Pending_1_o, 0);

    // Forwarding: youngest queue entry wins, then the output stage.
    drive(1'b1, 5'd9, 32'h11, 1'b0); step();
    drive(1'b1, 5'd9, 32'h22, 1'b0); step();
    drive(1'b1, 5'd3, 32'h33, 1'b0); step();
    drive(1'b0, 5'd0, '0, 1'b0);
    Query_Register_1_i = 5'd9;
    Query_Register_2_i = 5'd0;
    #1;
    check("fwd_pend1", Pending_1_o, 1);
    check("fwd_data1", Fwd_Data_1_o, 32'h22);
    check("fwd_q0_pend", Pending_2_o, 0);
    check("fwd_q0_data", Fwd_Data_2_o, 0);
    Query_Register_2_i = 5'd3;
    #1;
    check("fwd_pend2", Pending_2_o, 1);
    check("fwd_data2", Fwd_Data_2_o, 32'h33);
    drain_en_i = 1'b1;
    step();
    check("fwd_d1_pend1", Pending_1_o, 1);
    check("fwd_d1_data1", Fwd_Data_1_o, 32'h22);
    step();
    check("fwd_d2_pend1", Pending_1_o, 1);
    check("fwd_d2_data1_outstage", Fwd_Data_1_o, 32'h22);
    step();
    check("fwd_d3_pend1", Pending_1_o, 0);
    check("fwd_d3_data1", Fwd_Data_1_o, 0);
    check("fwd_d3_pend2_outstage", Pending_2_o, 1);
    check("fwd_d3_data2_outstage", Fwd_Data_2_o, 32'h33);
    step();
    check("fwd_d4_pend2", Pending_2_o, 0);
    check("fwd_count", count_o, 0);

    // Simultaneous accept and pop at count 2, wrapping the pointers.
    drive(1'b1, 5'd10, 32'hA0, 1'b0); step();
    drive(1'b1, 5'd11, 32'hA1, 1'b0); step();
    check("simul_pre_count", count_o, 2);
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 5'(12 + k), $urandom, 1'b1);
      step();
      check("simul_count", count_o, 2);
    end
    drain_all();

    // Reset mid-operation discards queued entries.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'(20 + k), 32'hB0 + 32'(k), 1'b0);
      step();
    end
    check("mid_pre_count", count_o, 3);
    Query_Register_1_i = 5'd20;
    reset = 1'b1;
    drive(1'b1, 5'd23, 32'hB3, 1'b1);
    step();
    reset = 1'b0;
    drive(1'b0, 5'd0, '0, 1'b1);
    #1;
    check("mid_count", count_o, 0);
    check("mid_rw", Reg_Write_o, 0);
    check("mid_ready", wb_ready_o, 1);
    check("mid_pend1", Pending_1_o, 0);
    for (int k = 0; k < 8; k++) step();
    check("mid_no_stale_rw", Reg_Write_o, 0);
    check("mid_final_count", count_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
